// File: rtl/sha256_round_engine.sv
// SHA-256 compression core: one round per accepted schedule word,
// followed by a final add of the working variables into the chaining value.
module sha256_round_engine #(
    parameter int ROUNDS = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [255:0]               hash_in,
    input  logic                       w_valid,
    input  logic [31:0]                w_word,
    output logic                       w_ready,
    output logic [$clog2(ROUNDS)-1:0]  round_index,
    output logic                       busy,
    output logic                       done,
    output logic [255:0]               hash_out
);

    localparam int IW = $clog2(ROUNDS);
    localparam logic [IW-1:0] LAST = IW'(ROUNDS - 1);

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    state_t state, state_nx;

    logic [31:0]  a, b, c, d, e, f, g, h;
    logic [255:0] h_lat;
    logic [31:0]  t1, t2;
    logic         xfer;

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    assign xfer = w_valid && w_ready;

    // Round function for the word currently on w_word
    always_comb begin
        t1 = h + big_s1(e) + ((e & f) ^ (~e & g)) + K[round_index] + w_word;
        t2 = big_s0(a) + ((a & b) ^ (a & c) ^ (b & c));
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = ROUND;
            ROUND:   if (xfer && round_index == LAST) state_nx = FINAL;
            FINAL:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake and status decoded from state
    always_comb begin
        w_ready = (state == ROUND);
        busy    = (state != IDLE);
    end

    // Working variables, chaining latch, round counter and result
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {a, b, c, d, e, f, g, h} <= '0;
            h_lat       <= '0;
            round_index <= '0;
            hash_out    <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        h_lat                    <= hash_in;
                        {a, b, c, d, e, f, g, h} <= hash_in;
                        round_index              <= '0;
                    end
                end
                ROUND: begin
                    if (xfer) begin
                        h           <= g;
                        g           <= f;
                        f           <= e;
                        e           <= d + t1;
                        d           <= c;
                        c           <= b;
                        b           <= a;
                        a           <= t1 + t2;
                        round_index <= round_index + 1'b1;
                    end
                end
                FINAL: begin
                    hash_out <= {h_lat[255:224] + a, h_lat[223:192] + b,
                                 h_lat[191:160] + c, h_lat[159:128] + d,
                                 h_lat[127:96]  + e, h_lat[95:64]   + f,
                                 h_lat[63:32]   + g, h_lat[31:0]    + h};
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
